// File: rtl/nlprg_period_mon.sv
// nlprg_period_mon: measures the period of an nlprg PRNG word stream from a
// captured reference word. It flags short-period, stuck and overrun faults, and
// it reports pass when the period is exactly 2^N.
// Optional build macro NLPRG_PERIOD_MON_SIG_EN adds a running XOR signature
// output (sig). When the macro is set, pass also requires sig == 0.
module nlprg_period_mon #(
  parameter int unsigned N = 11
) (
  input  logic         ck,
  input  logic         rst,
  input  logic         start,
  input  logic         in_vld,
  input  logic [N-1:0] in_dat,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   period,
  output logic [1:0]   err
`ifdef NLPRG_PERIOD_MON_SIG_EN
  ,
  output logic [N-1:0] sig
`endif
);

  localparam int unsigned CW = N + 1;
  localparam logic [CW-1:0] FULL = {1'b1, {N{1'b0}}};

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_SHORT = 2'b01;
  localparam logic [1:0] ERR_OVER  = 2'b10;
  localparam logic [1:0] ERR_STUCK = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state, w_state;
  logic [N-1:0]    r_ref, w_ref;
  logic [N-1:0]    r_prev, w_prev;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic            r_busy, w_busy;
  logic            r_done, w_done;
  logic            r_pass, w_pass;
  logic [CW-1:0]   r_period, w_period;
  logic [1:0]      r_err, w_err;
  logic [CW-1:0]   w_k;
  logic            w_sig_ok;
`ifdef NLPRG_PERIOD_MON_SIG_EN
  logic [N-1:0]    r_sig, w_sig;
`endif

  // Next-state and result computation; start always overrides a verdict
  always_comb begin
    w_state  = r_state;
    w_ref    = r_ref;
    w_prev   = r_prev;
    w_cnt    = r_cnt;
    w_done   = r_done;
    w_pass   = r_pass;
    w_period = r_period;
    w_err    = r_err;
    w_k      = r_cnt + CW'(1);
`ifdef NLPRG_PERIOD_MON_SIG_EN
    w_sig    = r_sig;
    w_sig_ok = (r_sig == '0);
`else
    w_sig_ok = 1'b1;
`endif

    if (start) begin
      w_state  = S_ARM;
      w_cnt    = '0;
      w_done   = 1'b0;
      w_pass   = 1'b0;
      w_period = '0;
      w_err    = ERR_NONE;
`ifdef NLPRG_PERIOD_MON_SIG_EN
      w_sig    = '0;
`endif
    end else begin
      case (r_state)
        S_ARM: begin
          if (in_vld) begin
            w_ref   = in_dat;
            w_prev  = in_dat;
            w_cnt   = '0;
            w_state = S_RUN;
`ifdef NLPRG_PERIOD_MON_SIG_EN
            w_sig   = in_dat;
`endif
          end
        end
        S_RUN: begin
          if (in_vld) begin
`ifdef NLPRG_PERIOD_MON_SIG_EN
            // The word that closes the loop on ref does not enter the signature
            if (in_dat != r_ref) w_sig = r_sig ^ in_dat;
`endif
            if (in_dat == r_ref) begin
              w_period = w_k;
              w_done   = 1'b1;
              w_state  = S_DONE;
              if ((w_k == FULL) && w_sig_ok) begin
                w_pass = 1'b1;
                w_err  = ERR_NONE;
              end else begin
                w_pass = 1'b0;
                w_err  = ERR_SHORT;
              end
            end else if (in_dat == r_prev) begin
              w_period = w_k;
              w_done   = 1'b1;
              w_pass   = 1'b0;
              w_err    = ERR_STUCK;
              w_state  = S_DONE;
            end else if (w_k == FULL) begin
              w_period = w_k;
              w_done   = 1'b1;
              w_pass   = 1'b0;
              w_err    = ERR_OVER;
              w_state  = S_DONE;
            end else begin
              w_cnt  = w_k;
              w_prev = in_dat;
            end
          end
        end
        default: ;
      endcase
    end

    w_busy = (w_state == S_ARM) || (w_state == S_RUN);
  end

  // State and result registers
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ref    <= '0;
      r_prev   <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_period <= '0;
      r_err    <= ERR_NONE;
`ifdef NLPRG_PERIOD_MON_SIG_EN
      r_sig    <= '0;
`endif
    end else begin
      r_state  <= w_state;
      r_ref    <= w_ref;
      r_prev   <= w_prev;
      r_cnt    <= w_cnt;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_pass   <= w_pass;
      r_period <= w_period;
      r_err    <= w_err;
`ifdef NLPRG_PERIOD_MON_SIG_EN
      r_sig    <= w_sig;
`endif
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign pass   = r_pass;
  assign period = r_period;
  assign err    = r_err;
`ifdef NLPRG_PERIOD_MON_SIG_EN
  assign sig    = r_sig;
`endif

endmodule

// File: tb/tb_nlprg_period_mon.sv
// Scoreboard bench for nlprg_period_mon. A list-level model derives each
// verdict from the accepted word list. A monitor compares the DUT outputs
// whenever done rises.
module tb_nlprg_period_mon;

  localparam int unsigned N = 11;
  localparam int M = 1 << N;
`ifdef NLPRG_PERIOD_MON_SIG_EN
  localparam bit SIG = 1'b1;
`else
  localparam bit SIG = 1'b0;
`endif

  logic         ck = 1'b0;
  logic         rst;
  logic         start;
  logic         in_vld;
  logic [N-1:0] in_dat;
  logic         busy;
  logic         done;
  logic         pass;
  logic [N:0]   period;
  logic [1:0]   err;
`ifdef NLPRG_PERIOD_MON_SIG_EN
  logic [N-1:0] sig;
`endif

  nlprg_period_mon #(.N(N)) dut (
    .ck     (ck),
    .rst    (rst),
    .start  (start),
    .in_vld (in_vld),
    .in_dat (in_dat),
    .busy   (busy),
    .done   (done),
    .pass   (pass),
    .period (period),
    .err    (err)
`ifdef NLPRG_PERIOD_MON_SIG_EN
    ,
    .sig    (sig)
`endif
  );

  always #5 ck = ~ck;

  typedef struct {
    int pass;
    int period;
    int err;
    int sig;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Walk the accepted words. Word 0 is the reference. Find the first word that
  // repeats the reference, repeats its predecessor, or reaches index 2^N.
  function automatic void model(input int w[$], output exp_t e, output int d);
    int s;
    e = '{0, 0, 0, 0};
    d = -1;
    s = w[0];
    for (int i = 1; i < w.size(); i++) begin
      if (w[i] == w[0]) begin
        d = i;
        e.period = i;
        e.pass = ((i == M) && (!SIG || s == 0)) ? 1 : 0;
        e.err = e.pass ? 0 : 1;
        e.sig = s;
        return;
      end
      s = s ^ w[i];
      if (w[i] == w[i-1] || i == M) begin
        d = i;
        e.period = i;
        e.err = (w[i] == w[i-1]) ? 3 : 2;
        e.sig = s;
        return;
      end
    end
  endfunction

  // Drive one cycle of inputs. The values are sampled at the next rising edge.
  task automatic drive(input bit s, input bit v, input int dat);
    start  = s;
    in_vld = v;
    in_dat = N'(dat);
    @(posedge ck);
    #1;
  endtask

  task automatic send(input int dat, input int gap_pct);
    for (int g = 0; g < 5 && int'($urandom_range(99)) < gap_pct; g++)
      drive(1'b0, 1'b0, int'($urandom));
    drive(1'b0, 1'b1, dat);
  endtask

  task automatic start_pulse(input bit v, input int dat);
    drive(1'b1, v, dat);
    chk("start_busy", int'(busy), 1);
    chk("start_done_clr", int'(done), 0);
    chk("start_period_clr", int'(period), 0);
    chk("start_err_clr", int'(err), 0);
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) drive(1'b0, 1'b0, 0);
    chk("verdict_timeout", exp_q.size(), 0);
  endtask

  // Full measurement. The start cycle may carry a valid word, which must be ignored.
  task automatic run(input int w[$], input int gap, input bit v_on_start, input int start_dat);
    exp_t e;
    int   d;
    model(w, e, d);
    start_pulse(v_on_start, start_dat);
    if (d >= 0) exp_q.push_back(e);
    for (int i = 0; i < w.size() && (d < 0 || i <= d); i++) send(w[i], gap);
    drive(1'b0, 1'b0, 0);
    if (d >= 0) begin
      wait_drain();
      for (int i = 0; i < 3; i++) send(int'($urandom), 0);
      chk("sticky_done", int'(done), 1);
      chk("sticky_period", int'(period), e.period);
    end
  endtask

  // Drive start and the first cnt words, with no verdict expected.
  task automatic prefix(input int w[$], input int cnt);
    start_pulse(1'b0, 0);
    for (int i = 0; i < cnt; i++) send(w[i], 0);
  endtask

  // Scoreboard monitor: compare on every rising edge of done
  bit done_q = 1'b0;
  always @(negedge ck) begin
    if (done && !done_q) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_verdict", 1, 0);
      end else begin
        last_exp = exp_q.pop_front();
        chk("pass", int'(pass), last_exp.pass);
        chk("period", int'(period), last_exp.period);
        chk("err", int'(err), last_exp.err);
        chk("busy_at_verdict", int'(busy), 0);
`ifdef NLPRG_PERIOD_MON_SIG_EN
        chk("sig", int'(sig), last_exp.sig);
`endif
      end
    end
    done_q = done;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int perm[$], shrt[$], stuck[$], over[$], w[$], bad[$];
    int p, a, b;

    rst = 1'b1; start = 1'b0; in_vld = 1'b0; in_dat = '0;
    repeat (2) @(negedge ck);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_period", int'(period), 0);
    chk("rst_err", int'(err), 0);
    @(posedge ck); #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, 0);

    for (int i = 0; i <= M; i++) perm.push_back((5 + 3 * i) % M);
    for (int i = 0; i <= 1000; i++) shrt.push_back((5 + 3 * (i % 1000)) % M);
    stuck = '{'h011, 'h022, 'h033, 'h044, 'h055, 'h066, 'h077, 'h155, 'h155};
    over.push_back(0);
    for (int i = 1; i <= M; i++) over.push_back(((i - 1) % (M - 1)) + 1);

    run(perm, 0, 1'b0, 0);
    run(shrt, 0, 1'b0, 0);
    run(stuck, 0, 1'b0, 0);
    run(over, 0, 1'b0, 0);
    run(perm, 30, 1'b0, 0);

    // Abort at sample 500. The start cycle's valid word is ignored, and the next word becomes ref.
    prefix(perm, 500);
    run(shrt, 0, 1'b1, perm[500]);

    // Start coincides with the deciding stuck word. No verdict is recorded.
    prefix(stuck, 8);
    run(shrt, 10, 1'b1, stuck[8]);

    // Reset at sample 300
    prefix(perm, 300);
    rst = 1'b1;
    #2;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_period", int'(period), 0);
    chk("midrst_err", int'(err), 0);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) send(perm[i], 0);
    drive(1'b0, 1'b0, 0);
    chk("idle_ignores_busy", int'(busy), 0);
    chk("idle_ignores_done", int'(done), 0);
    run(perm, 0, 1'b0, 0);

    // One word replaced by a non-adjacent duplicate. The period is still full, but the signature is nonzero.
    bad = perm;
    bad[1000] = perm[500];
    run(bad, 0, 1'b0, 0);

    // Randomized affine sequences with random period and gaps
    for (int r = 0; r < 4; r++) begin
      p = int'($urandom_range(2, M));
      a = int'($urandom_range(0, M - 1));
      b = 2 * int'($urandom_range(0, M / 2 - 1)) + 1;
      w.delete();
      for (int i = 0; i <= p; i++) w.push_back((a + b * (i % p)) % M);
      run(w, 20, 1'b0, 0);
    end

    // Random small-alphabet streams. These hit stuck and short cases, and sometimes end unresolved.
    for (int r = 0; r < 20; r++) begin
      w.delete();
      for (int i = 0; i < 30; i++) w.push_back(int'($urandom_range(0, 7)));
      run(w, 20, 1'b0, 0);
    end

    drive(1'b0, 1'b0, 0);
    wait_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
